// File: rtl/font_render_scheduler_pkg.sv
// Shared types for the font render scheduler.
//   CharGrid_t     : one text-buffer cell (glyph code plus colours)
//   SramAddress_t  : pixel word address in the framebuffer SRAM
//   SramRequest_t  : single SRAM access (active-high den, active-low we_n/oe_n)
//   SchedState_t   : scheduler FSM state, also exported as a debug output
// Console geometry defaults live here; the top exposes them as parameters.
package font_render_scheduler_pkg;

    localparam int DEF_COLUMNS     = 80;
    localparam int DEF_ROWS        = 30;
    localparam int DEF_CHAR_W      = 8;
    localparam int DEF_CHAR_H      = 16;
    localparam int DEF_LINE_STRIDE = 640;
    localparam int DEF_BUF0_BASE   = 0;
    localparam int DEF_BUF1_BASE   = 307200;

    // Two 640x480 buffers need 614400 words, which fits in 20 bits.
    localparam int SRAM_AW = 20;

    typedef logic [SRAM_AW-1:0] SramAddress_t;

    typedef struct packed {
        logic [7:0] code;
        logic [3:0] fg;
        logic [3:0] bg;
    } CharGrid_t;

    typedef struct packed {
        logic         den;
        logic         we_n;
        logic         oe_n;
        SramAddress_t address;
    } SramRequest_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_RENDER,
        ST_RELEASE,
        ST_FINISH
    } SchedState_t;

    localparam SramRequest_t SRAM_IDLE = '{den: 1'b0, we_n: 1'b1, oe_n: 1'b1, address: '0};

endpackage

// File: rtl/font_render_scheduler_if.sv
// Bus between the scheduler and its surroundings (request source, text
// buffer, renderer and SRAM). The master modport is the scheduler side.
//
// Handshake: frameStart and cellReq are single-cycle request pulses with no
// back-pressure; the scheduler records them and reports progress on busy.
// cellData answers cellAddr one cycle later. The renderer runs while
// rendererRst is high and signals completion with rendererDone; rendererReq is
// forwarded to ramRequest only while the renderer is released.
interface font_render_scheduler_if;

    logic                                       frameStart;
    logic                                       cellReq;
    logic [6:0]                                 cellReqCol;
    logic [4:0]                                 cellReqRow;
    logic [11:0]                                cellAddr;
    font_render_scheduler_pkg::CharGrid_t       cellData;
    font_render_scheduler_pkg::CharGrid_t       grid;
    font_render_scheduler_pkg::SramAddress_t    baseAddress;
    logic                                       rendererRst;
    logic                                       rendererDone;
    font_render_scheduler_pkg::SramRequest_t    rendererReq;
    font_render_scheduler_pkg::SramRequest_t    ramRequest;
    logic                                       displaySel;
    logic                                       busy;
    logic                                       frameDone;
    font_render_scheduler_pkg::SchedState_t     stateDbg;

    modport master (
        input  frameStart, cellReq, cellReqCol, cellReqRow, cellData,
               rendererDone, rendererReq,
        output cellAddr, grid, baseAddress, rendererRst, ramRequest,
               displaySel, busy, frameDone, stateDbg
    );

    modport slave (
        output frameStart, cellReq, cellReqCol, cellReqRow, cellData,
               rendererDone, rendererReq,
        input  cellAddr, grid, baseAddress, rendererRst, ramRequest,
               displaySel, busy, frameDone, stateDbg
    );

endinterface

// File: rtl/font_render_scheduler_render_cursor.sv
// Column/row cursor over the character console.
//   clk, rst          : clock, asynchronous active-low reset
//   load              : load loadCol/loadRow (start of a job)
//   advance           : step to the next cell in raster order
//   col, row          : current cell
//   lastCell          : cursor sits on the bottom-right cell
module font_render_scheduler_render_cursor #(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] loadCol,
    input  logic [4:0] loadRow,
    input  logic       advance,
    output logic [6:0] col,
    output logic [4:0] row,
    output logic       lastCell
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            col <= loadCol;
            row <= loadRow;
        end else if (advance) begin
            if (col == 7'(COLUMNS - 1)) begin
                col <= '0;
                row <= (row == 5'(ROWS - 1)) ? '0 : row + 5'd1;
            end else begin
                col <= col + 7'd1;
            end
        end
    end

    assign lastCell = (col == 7'(COLUMNS - 1)) && (row == 5'(ROWS - 1));

endmodule

// File: rtl/font_render_scheduler.sv
// Font render scheduler: walks the console (whole frame or one cell), fetches
// each cell from the text buffer, drives the per-cell renderer and gates its
// SRAM request. Whole frames render into the hidden buffer and flip it.
//   clk  : clock
//   rst  : asynchronous reset, active low
//   bus  : font_render_scheduler_if.master (requests, text buffer, renderer,
//          SRAM, status and FSM state for debug)
module font_render_scheduler
    import font_render_scheduler_pkg::*;
#(
    parameter int COLUMNS     = DEF_COLUMNS,
    parameter int ROWS        = DEF_ROWS,
    parameter int CHAR_W      = DEF_CHAR_W,
    parameter int CHAR_H      = DEF_CHAR_H,
    parameter int LINE_STRIDE = DEF_LINE_STRIDE,
    parameter int BUF0_BASE   = DEF_BUF0_BASE,
    parameter int BUF1_BASE   = DEF_BUF1_BASE
) (
    input  logic                    clk,
    input  logic                    rst,
    font_render_scheduler_if.master bus
);

    SchedState_t state, stateNext;

    logic       isFull;        // current job is a whole frame
    logic       target;        // framebuffer the current job writes
    logic       fullPending;
    logic       singlePending;
    logic [6:0] pendCol;
    logic [4:0] pendRow;

    logic       cellValid;
    logic       startFull;
    logic       startSingle;
    logic       jobLast;
    logic [6:0] curCol;
    logic [4:0] curRow;
    logic       cursorLast;

    assign cellValid   = bus.cellReq && (bus.cellReqCol < 7'(COLUMNS)) && (bus.cellReqRow < 5'(ROWS));
    // Pulses arriving in IDLE are served directly, so a same-cycle pair is not lost.
    assign startFull   = (state == ST_IDLE) && (fullPending || bus.frameStart);
    assign startSingle = (state == ST_IDLE) && !startFull && (singlePending || cellValid);
    assign jobLast     = isFull ? cursorLast : 1'b1;

    font_render_scheduler_render_cursor #(
        .COLUMNS (COLUMNS),
        .ROWS    (ROWS)
    ) u_cursor (
        .clk      (clk),
        .rst      (rst),
        .load     (startFull || startSingle),
        .loadCol  (startFull ? 7'd0 : (cellValid ? bus.cellReqCol : pendCol)),
        .loadRow  (startFull ? 5'd0 : (cellValid ? bus.cellReqRow : pendRow)),
        .advance  ((state == ST_RELEASE) && isFull && !cursorLast),
        .col      (curCol),
        .row      (curRow),
        .lastCell (cursorLast)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:    if (startFull || startSingle) stateNext = ST_FETCH;
            ST_FETCH:   stateNext = ST_LATCH;
            ST_LATCH:   stateNext = ST_RENDER;
            ST_RENDER:  if (bus.rendererDone) stateNext = ST_RELEASE;
            ST_RELEASE: stateNext = jobLast ? ST_FINISH : ST_FETCH;
            ST_FINISH:  stateNext = ST_IDLE;
            default:    stateNext = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.rendererRst = (state == ST_RENDER);
        bus.ramRequest  = (state == ST_RENDER) ? bus.rendererReq : SRAM_IDLE;
        // Pending work keeps busy up across the IDLE cycle between jobs.
        bus.busy        = (state != ST_IDLE) || fullPending || singlePending;
        bus.cellAddr    = 12'(int'(curRow) * COLUMNS + int'(curCol));
        bus.stateDbg    = state;
    end

    // Job bookkeeping, latched cell and framebuffer selection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            isFull          <= 1'b0;
            target          <= 1'b0;
            fullPending     <= 1'b0;
            singlePending   <= 1'b0;
            pendCol         <= '0;
            pendRow         <= '0;
            bus.grid        <= '0;
            bus.baseAddress <= SramAddress_t'(BUF0_BASE);
            bus.displaySel  <= 1'b0;
            bus.frameDone   <= 1'b0;
        end else begin
            bus.frameDone <= (state == ST_FINISH) && isFull;
            if ((state == ST_FINISH) && isFull) begin
                bus.displaySel <= ~bus.displaySel;
            end

            if (startFull) begin
                isFull        <= 1'b1;
                target        <= ~bus.displaySel;
                fullPending   <= 1'b0;
                // An older single request is covered by the frame; one arriving now is kept.
                singlePending <= cellValid;
            end else if (startSingle) begin
                isFull        <= 1'b0;
                target        <= bus.displaySel;
                singlePending <= 1'b0;
            end else begin
                if (bus.frameStart) fullPending <= 1'b1;
                if (cellValid) singlePending <= 1'b1;
            end

            if (cellValid && !startSingle) begin
                pendCol <= bus.cellReqCol;
                pendRow <= bus.cellReqRow;
            end

            if (state == ST_LATCH) begin
                bus.grid        <= bus.cellData;
                bus.baseAddress <= (target ? SramAddress_t'(BUF1_BASE) : SramAddress_t'(BUF0_BASE))
                                 + SramAddress_t'(curRow) * SramAddress_t'(CHAR_H * LINE_STRIDE)
                                 + SramAddress_t'(curCol) * SramAddress_t'(CHAR_W);
            end
        end
    end

endmodule

// File: tb/tb_font_render_scheduler.sv
// Bench for font_render_scheduler on a 4x2 console. Renderer model asserts
// rendererDone on the third cycle after release; the text buffer returns a
// grid derived from the address one cycle after cellAddr.
module tb_font_render_scheduler;
    import font_render_scheduler_pkg::*;

    localparam int BUF1 = 307200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    font_render_scheduler_if bus ();

    font_render_scheduler #(
        .COLUMNS (4),
        .ROWS    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- environment models ----------------
    function automatic CharGrid_t gridFor(input logic [11:0] a);
        CharGrid_t g;
        g.code = 8'h40 + a[7:0];
        g.fg   = a[3:0];
        g.bg   = ~a[3:0];
        return g;
    endfunction

    always @(posedge clk) bus.cellData <= gridFor(bus.cellAddr);

    int rendCnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) rendCnt <= 0;
        else      rendCnt <= bus.rendererRst ? rendCnt + 1 : 0;
    end
    assign bus.rendererDone = bus.rendererRst && (rendCnt == 2);

    // ---------------- monitor (observation only) ----------------
    logic [11:0]  obsAddrQ[$];
    logic [19:0]  obsBaseQ[$];
    CharGrid_t    obsGridQ[$];
    int           denCnt = 0;
    int           gateBad = 0;
    int           frameDoneCnt = 0;
    logic         prevRendRst = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.stateDbg == ST_FETCH) obsAddrQ.push_back(bus.cellAddr);
            if (bus.rendererRst && !prevRendRst) begin
                obsBaseQ.push_back(bus.baseAddress);
                obsGridQ.push_back(bus.grid);
            end
            if (bus.ramRequest.den) denCnt <= denCnt + 1;
            if (bus.ramRequest !== (bus.rendererRst ? bus.rendererReq : SRAM_IDLE)) gateBad <= gateBad + 1;
            if (bus.frameDone) frameDoneCnt <= frameDoneCnt + 1;
            prevRendRst <= bus.rendererRst;
        end else begin
            prevRendRst <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [11:0] expAddrQ[$];
    logic [19:0] expBaseQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushCell(input int col, input int row, input int sel);
        expAddrQ.push_back(12'(row * 4 + col));
        expBaseQ.push_back(20'((sel != 0 ? BUF1 : 0) + row * 16 * 640 + col * 8));
    endtask

    task automatic pushFrame(input int sel);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                pushCell(c, r, sel);
    endtask

    task automatic verifyJob(input string name, input int aStart, input int bStart);
        check({name, " fetch count"}, 32'(obsAddrQ.size() - aStart), 32'(expAddrQ.size()));
        check({name, " render count"}, 32'(obsBaseQ.size() - bStart), 32'(expBaseQ.size()));
        for (int i = 0; i < expAddrQ.size(); i++) begin
            if (aStart + i < obsAddrQ.size())
                check($sformatf("%s cellAddr[%0d]", name, i), 32'(obsAddrQ[aStart + i]), 32'(expAddrQ[i]));
            if (bStart + i < obsBaseQ.size()) begin
                check($sformatf("%s baseAddress[%0d]", name, i), 32'(obsBaseQ[bStart + i]), 32'(expBaseQ[i]));
                check($sformatf("%s grid[%0d]", name, i), 32'(obsGridQ[bStart + i]), 32'(gridFor(expAddrQ[i])));
            end
        end
        expAddrQ.delete();
        expBaseQ.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic pulse(input logic f, input logic c, input logic [6:0] col, input logic [4:0] row);
        @(posedge clk); #1;
        bus.frameStart = f;
        bus.cellReq    = c;
        bus.cellReqCol = col;
        bus.cellReqRow = row;
        @(posedge clk); #1;
        bus.frameStart = 1'b0;
        bus.cellReq    = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.stateDbg != ST_IDLE) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s idle timeout: busy=%0b after %0d cycles, expected 0", name, bus.busy, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic waitFrameDone(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.frameDone && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s frameDone timeout: frameDone=0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // ---------------- single-cell vectors ----------------
    typedef struct {
        logic [6:0]  col;
        logic [4:0]  row;
        bit          valid;
        logic [11:0] expAddr;
        logic [19:0] expBase;
    } CellVec_t;

    CellVec_t vecs[6];

    int aS, bS, dS, gS, fS;

    initial begin
        // displaySel is 1 when the table runs, so valid cells land in buffer 1.
        vecs[0] = '{col: 7'd2, row: 5'd1, valid: 1'b1, expAddr: 12'd6, expBase: 20'd317456};
        vecs[1] = '{col: 7'd0, row: 5'd0, valid: 1'b1, expAddr: 12'd0, expBase: 20'd307200};
        vecs[2] = '{col: 7'd3, row: 5'd1, valid: 1'b1, expAddr: 12'd7, expBase: 20'd317464};
        vecs[3] = '{col: 7'd3, row: 5'd0, valid: 1'b1, expAddr: 12'd3, expBase: 20'd307224};
        vecs[4] = '{col: 7'd4, row: 5'd0, valid: 1'b0, expAddr: 12'd0, expBase: 20'd0};
        vecs[5] = '{col: 7'd0, row: 5'd2, valid: 1'b0, expAddr: 12'd0, expBase: 20'd0};

        bus.frameStart  = 1'b0;
        bus.cellReq     = 1'b0;
        bus.cellReqCol  = '0;
        bus.cellReqRow  = '0;
        bus.rendererReq = '{den: 1'b1, we_n: 1'b0, oe_n: 1'b1, address: 20'h12345};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset rendererRst", 32'(bus.rendererRst), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset frameDone", 32'(bus.frameDone), 32'd0);
        check("reset displaySel", 32'(bus.displaySel), 32'd0);
        check("reset cellAddr", 32'(bus.cellAddr), 32'd0);
        check("reset grid", 32'(bus.grid), 32'd0);
        check("reset baseAddress", 32'(bus.baseAddress), 32'd0);
        check("reset ramRequest", 32'(bus.ramRequest), 32'(SRAM_IDLE));
        @(negedge clk);
        rst = 1'b1;

        // 1. Full frame into buffer 1
        aS = obsAddrQ.size(); bS = obsBaseQ.size(); dS = denCnt; gS = gateBad; fS = frameDoneCnt;
        pushFrame(1);
        pulse(1'b1, 1'b0, 7'd0, 5'd0);
        @(negedge clk);
        check("frame busy", 32'(bus.busy), 32'd1);
        waitFrameDone("frame", 400);
        check("frame displaySel at frameDone", 32'(bus.displaySel), 32'd1);
        waitIdle("frame", 400);
        if (bS + 5 < obsBaseQ.size())
            check("frame base col1 row1", 32'(obsBaseQ[bS + 5]), 32'd317448);
        verifyJob("frame", aS, bS);
        check("frame frameDone pulses", 32'(frameDoneCnt - fS), 32'd1);
        check("frame displaySel", 32'(bus.displaySel), 32'd1);
        check("frame den cycles", 32'(denCnt - dS), 32'd24);
        check("frame gating", 32'(gateBad - gS), 32'd0);

        // 2/6. Single cells, including out-of-range requests
        for (int i = 0; i < 6; i++) begin
            aS = obsAddrQ.size(); bS = obsBaseQ.size(); dS = denCnt; fS = frameDoneCnt;
            if (vecs[i].valid) begin
                expAddrQ.push_back(vecs[i].expAddr);
                expBaseQ.push_back(vecs[i].expBase);
            end
            pulse(1'b0, 1'b1, vecs[i].col, vecs[i].row);
            if (vecs[i].valid) begin
                waitIdle($sformatf("cell%0d", i), 100);
                check($sformatf("cell%0d den cycles", i), 32'(denCnt - dS), 32'd3);
            end else begin
                repeat (3) begin
                    @(negedge clk);
                    check($sformatf("cell%0d ignored busy", i), 32'(bus.busy), 32'd0);
                end
            end
            verifyJob($sformatf("cell%0d", i), aS, bS);
            check($sformatf("cell%0d no frameDone", i), 32'(frameDoneCnt - fS), 32'd0);
        end
        check("cells displaySel", 32'(bus.displaySel), 32'd1);

        // 3a. cellReq during a frame is served after it, busy held across the gap
        aS = obsAddrQ.size(); bS = obsBaseQ.size(); dS = denCnt; fS = frameDoneCnt;
        pushFrame(0);
        pushCell(1, 0, 0);
        pulse(1'b1, 1'b0, 7'd0, 5'd0);
        repeat (5) @(posedge clk);
        pulse(1'b0, 1'b1, 7'd1, 5'd0);
        waitFrameDone("queued", 400);
        check("queued busy at frameDone", 32'(bus.busy), 32'd1);
        waitIdle("queued", 400);
        verifyJob("queued", aS, bS);
        check("queued frameDone pulses", 32'(frameDoneCnt - fS), 32'd1);
        check("queued displaySel", 32'(bus.displaySel), 32'd0);
        check("queued den cycles", 32'(denCnt - dS), 32'd27);

        // 3b. frameStart and cellReq in the same IDLE cycle
        aS = obsAddrQ.size(); bS = obsBaseQ.size(); fS = frameDoneCnt;
        pushFrame(1);
        pushCell(3, 1, 1);
        pulse(1'b1, 1'b1, 7'd3, 5'd1);
        waitIdle("same-cycle", 400);
        verifyJob("same-cycle", aS, bS);
        check("same-cycle frameDone pulses", 32'(frameDoneCnt - fS), 32'd1);
        check("same-cycle displaySel", 32'(bus.displaySel), 32'd1);

        // 5. Reset during RENDER
        fS = frameDoneCnt;
        pulse(1'b1, 1'b0, 7'd0, 5'd0);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus.rendererRst && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("midreset reached RENDER", 32'(bus.rendererRst), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midreset rendererRst", 32'(bus.rendererRst), 32'd0);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset ramRequest", 32'(bus.ramRequest), 32'(SRAM_IDLE));
        check("midreset displaySel", 32'(bus.displaySel), 32'd0);
        check("midreset frameDone", 32'(bus.frameDone), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("after reset no frameDone", 32'(frameDoneCnt - fS), 32'd0);
        check("after reset busy", 32'(bus.busy), 32'd0);
        check("overall gating", 32'(gateBad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1);
    end

endmodule
